// File: rtl/qar_bus_pkg.sv
// Shared types and constants for the QAR-Core memory arbiter.
// State and owner encodings are used by the top level and the pick logic.
package qar_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  STARVE_SAT       = 4'd15;

endpackage

// File: rtl/qar_arb_pick.sv
// Combinational winner selection between the fetch (I) and data (D) ports.
// The starvation guard overrides both the fixed-priority and round-robin modes.
module qar_arb_pick
  import qar_bus_pkg::*;
#(
  parameter int DATA_PRIO  = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic [3:0] starve_cnt,
  input  owner_t     last_owner,
  output logic       grant,
  output owner_t     winner
);

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  always_comb begin
    grant  = i_valid | d_valid;
    winner = OWNER_D;
    if (i_valid && d_valid) begin
      if (starve_cnt >= STARVE_LIM) begin
        winner = OWNER_I;
      end else if (DATA_PRIO != 0) begin
        winner = OWNER_D;
      end else begin
        // Round-robin: hand the memory to whichever port did not use it last.
        winner = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
      end
    end else if (i_valid) begin
      winner = OWNER_I;
    end
  end

endmodule

// File: rtl/qar_mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between the fetch and data ports.
// Registered downstream request, combinational completion pass-through, timeout watchdog.
module qar_mem_arbiter
  import qar_bus_pkg::*;
#(
  parameter int          DATA_PRIO  = 1,
  parameter int          MAX_STARVE = 4,
  parameter int          TIMEOUT    = 256,
  parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  owner_t        last_owner;
  logic [3:0]    starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic   grant;
  owner_t winner;
  logic   busy;
  logic   done_ok;
  logic   done_tmo;
  logic   done;

  qar_arb_pick #(
    .DATA_PRIO  (DATA_PRIO),
    .MAX_STARVE (MAX_STARVE)
  ) u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .starve_cnt (starve_cnt),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

  assign busy     = (state == BUSY_I) || (state == BUSY_D);
  assign done_ok  = busy && m_ready;
  assign done_tmo = busy && !m_ready && (tmo_cnt == TMO_LAST);
  assign done     = done_ok || done_tmo;

  // Completion strobes are suppressed while reset is asserted so an aborted
  // request never produces a ready pulse.
  always_comb begin
    i_ready = 1'b0;
    i_err   = 1'b0;
    d_ready = 1'b0;
    d_err   = 1'b0;
    if (!rst && done) begin
      if (state == BUSY_I) begin
        i_ready = 1'b1;
        i_err   = done_tmo;
      end else begin
        d_ready = 1'b1;
        d_err   = done_tmo;
      end
    end
  end

  assign i_rdata = done_tmo ? ERR_DATA : m_rdata;
  assign d_rdata = done_tmo ? ERR_DATA : m_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      starve_cnt <= '0;
      last_owner <= OWNER_D;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant) begin
            m_valid <= 1'b1;
            if (winner == OWNER_I) begin
              m_we       <= 1'b0;
              m_addr     <= i_addr;
              m_wdata    <= '0;
              starve_cnt <= '0;
              state      <= BUSY_I;
            end else begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              state   <= BUSY_D;
              if (i_valid && (starve_cnt != STARVE_SAT)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // m_* stay frozen until completion; a timeout ends the transfer like a normal one.
          if (done) begin
            m_valid    <= 1'b0;
            last_owner <= (state == BUSY_I) ? OWNER_I : OWNER_D;
            tmo_cnt    <= '0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          m_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Directed bench for qar_mem_arbiter: u_a runs fixed priority, u_b round-robin,
// each behind its own small memory model with programmable wait/hold behaviour.
module tb_qar_mem_arbiter;
  import qar_bus_pkg::*;

  logic clk;
  logic rst;

  logic        i_valid [2];
  logic [31:0] i_addr  [2];
  logic        d_valid [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];

  logic [1:0]  i_ready;
  logic [31:0] i_rdata [2];
  logic [1:0]  i_err;
  logic [1:0]  d_ready;
  logic [31:0] d_rdata [2];
  logic [1:0]  d_err;
  logic [1:0]  m_valid;
  logic [1:0]  m_we;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_ready;
  logic [31:0] m_rdata [2];

  logic [31:0] mem      [2][16];
  logic [3:0]  wait_cnt [2];
  logic [3:0]  mem_wait [2];
  logic        mem_hold [2];

  int check_cnt = 0;
  int pass_cnt  = 0;

  qar_mem_arbiter #(
    .DATA_PRIO (1), .MAX_STARVE (4), .TIMEOUT (8), .ERR_DATA (32'hDEAD_BEEF)
  ) u_a (
    .clk (clk), .rst (rst),
    .i_valid (i_valid[0]), .i_addr (i_addr[0]), .i_ready (i_ready[0]),
    .i_rdata (i_rdata[0]), .i_err (i_err[0]),
    .d_valid (d_valid[0]), .d_we (d_we[0]), .d_addr (d_addr[0]), .d_wdata (d_wdata[0]),
    .d_ready (d_ready[0]), .d_rdata (d_rdata[0]), .d_err (d_err[0]),
    .m_valid (m_valid[0]), .m_we (m_we[0]), .m_addr (m_addr[0]), .m_wdata (m_wdata[0]),
    .m_ready (m_ready[0]), .m_rdata (m_rdata[0])
  );

  qar_mem_arbiter #(
    .DATA_PRIO (0), .MAX_STARVE (4), .TIMEOUT (8), .ERR_DATA (32'hDEAD_BEEF)
  ) u_b (
    .clk (clk), .rst (rst),
    .i_valid (i_valid[1]), .i_addr (i_addr[1]), .i_ready (i_ready[1]),
    .i_rdata (i_rdata[1]), .i_err (i_err[1]),
    .d_valid (d_valid[1]), .d_we (d_we[1]), .d_addr (d_addr[1]), .d_wdata (d_wdata[1]),
    .d_ready (d_ready[1]), .d_rdata (d_rdata[1]), .d_err (d_err[1]),
    .m_valid (m_valid[1]), .m_we (m_we[1]), .m_addr (m_addr[1]), .m_wdata (m_wdata[1]),
    .m_ready (m_ready[1]), .m_rdata (m_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input int k, input int w);
    return (k == 0) ? (32'hA000_0000 + 32'(w)) : (32'hB000_0000 + 32'(w));
  endfunction

  // Memory model: m_ready rises after mem_wait stall cycles unless held off entirely.
  always_comb begin
    m_ready = '0;
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = m_valid[k] && !mem_hold[k] && (wait_cnt[k] >= mem_wait[k]);
      m_rdata[k] = mem[k][m_addr[k][5:2]];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int w = 0; w < 16; w++) mem[k][w] <= memWord(k, w);
        wait_cnt[k] <= '0;
      end else begin
        if (m_valid[k] && m_ready[k] && m_we[k]) mem[k][m_addr[k][5:2]] <= m_wdata[k];
        if (!m_valid[k] || m_ready[k]) wait_cnt[k] <= '0;
        else wait_cnt[k] <= wait_cnt[k] + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic iv, input logic [31:0] ia,
                               input logic dv, input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd);
    i_valid[k] = iv;
    i_addr[k]  = ia;
    d_valid[k] = dv;
    d_we[k]    = dwe;
    d_addr[k]  = da;
    d_wdata[k] = dwd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  logic       exp_prio [10];
  logic       exp_rr   [4];
  logic [3:0] starve_model;

  initial begin
    exp_prio = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rr   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      mem_wait[k] = '0;
      mem_hold[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    settle();
    checkOutput("rst_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("rst_m_we", 32'(m_we[0]), 32'd0);
    checkOutput("rst_m_addr", m_addr[0], 32'h0);
    checkOutput("rst_m_wdata", m_wdata[0], 32'h0);
    checkOutput("rst_readies", {30'd0, i_ready[0], d_ready[0]}, 32'd0);
    checkOutput("rst_b_m_valid", 32'(m_valid[1]), 32'd0);

    // Single fetch, zero-wait memory: grant and completion both in cycle 1.
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("t1_c0_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("t1_c0_i_ready", 32'(i_ready[0]), 32'd0);
    tick();
    checkOutput("t1_m_valid", 32'(m_valid[0]), 32'd1);
    checkOutput("t1_m_addr", m_addr[0], 32'h10);
    checkOutput("t1_m_we", 32'(m_we[0]), 32'd0);
    checkOutput("t1_i_ready", 32'(i_ready[0]), 32'd1);
    checkOutput("t1_i_rdata", i_rdata[0], 32'hA000_0004);
    checkOutput("t1_i_err", 32'(i_err[0]), 32'd0);
    checkOutput("t1_d_ready", 32'(d_ready[0]), 32'd0);
    tick();
    applyStimulus(0, 1'b0, 32'h10, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("t1_c2_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("t1_c2_i_ready", 32'(i_ready[0]), 32'd0);

    // Both ports hammering: D wins until I has lost four times in a row.
    applyStimulus(0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0);
    starve_model = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      starve_model = exp_prio[t] ? 4'd0 : starve_model + 4'd1;
      checkOutput($sformatf("prio_i_ready_%0d", t), 32'(i_ready[0]), 32'(exp_prio[t]));
      checkOutput($sformatf("prio_d_ready_%0d", t), 32'(d_ready[0]), 32'(!exp_prio[t]));
      checkOutput($sformatf("prio_m_addr_%0d", t), m_addr[0], exp_prio[t] ? 32'h10 : 32'h20);
      checkOutput($sformatf("prio_starve_%0d", t), 32'(u_a.starve_cnt), 32'(starve_model));
      tick();
      if (t == 9) applyStimulus(0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h20, '0);
    end
    settle();

    // Memory never answers: watchdog completes the data read with an error.
    mem_hold[0] = 1'b1;
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0, 32'h24, '0);
    for (int c = 1; c < 8; c++) begin
      tick();
      checkOutput($sformatf("tmo_wait_d_ready_%0d", c), 32'(d_ready[0]), 32'd0);
    end
    tick();
    checkOutput("tmo_d_ready", 32'(d_ready[0]), 32'd1);
    checkOutput("tmo_d_err", 32'(d_err[0]), 32'd1);
    checkOutput("tmo_d_rdata", d_rdata[0], 32'hDEAD_BEEF);
    checkOutput("tmo_i_ready", 32'(i_ready[0]), 32'd0);
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, 32'h24, '0);
    tick();
    checkOutput("tmo_after_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("tmo_after_d_ready", 32'(d_ready[0]), 32'd0);

    // Reset lands while BUSY_D is stalled; the retried request then completes.
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0, 32'h2C, '0);
    tick();
    checkOutput("rstmid_m_valid", 32'(m_valid[0]), 32'd1);
    checkOutput("rstmid_state", 32'(u_a.state), 32'(BUSY_D));
    tick();
    rst = 1'b1;
    settle();
    checkOutput("rstmid_rst_d_ready", 32'(d_ready[0]), 32'd0);
    tick();
    rst = 1'b0;
    mem_hold[0] = 1'b0;
    settle();
    checkOutput("rstmid_after_m_valid", 32'(m_valid[0]), 32'd0);
    checkOutput("rstmid_after_state", 32'(u_a.state), 32'(IDLE));
    checkOutput("rstmid_after_d_ready", 32'(d_ready[0]), 32'd0);
    tick();
    checkOutput("rstmid_retry_d_ready", 32'(d_ready[0]), 32'd1);
    checkOutput("rstmid_retry_d_rdata", d_rdata[0], 32'hA000_000B);
    checkOutput("rstmid_retry_d_err", 32'(d_err[0]), 32'd0);
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, 32'h2C, '0);
    tick();

    // Three wait states; the requester's address change must not leak through.
    mem_wait[0] = 4'd3;
    applyStimulus(0, 1'b0, '0, 1'b1, 1'b0, 32'h28, '0);
    tick();
    checkOutput("wait_c1_m_addr", m_addr[0], 32'h28);
    checkOutput("wait_c1_d_ready", 32'(d_ready[0]), 32'd0);
    d_addr[0] = 32'h3C;
    for (int c = 2; c < 4; c++) begin
      tick();
      checkOutput($sformatf("wait_c%0d_d_ready", c), 32'(d_ready[0]), 32'd0);
      checkOutput($sformatf("wait_c%0d_m_addr", c), m_addr[0], 32'h28);
    end
    tick();
    checkOutput("wait_c4_d_ready", 32'(d_ready[0]), 32'd1);
    checkOutput("wait_c4_d_rdata", d_rdata[0], 32'hA000_000A);
    checkOutput("wait_c4_m_addr", m_addr[0], 32'h28);
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0, 32'h3C, '0);
    mem_wait[0] = '0;
    tick();

    // Round-robin instance alternates, starting with I since D owned it last at reset.
    applyStimulus(1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h8, 32'h0000_0064);
    for (int t = 0; t < 4; t++) begin
      tick();
      checkOutput($sformatf("rr_i_ready_%0d", t), 32'(i_ready[1]), 32'(exp_rr[t]));
      checkOutput($sformatf("rr_d_ready_%0d", t), 32'(d_ready[1]), 32'(!exp_rr[t]));
      if (exp_rr[t]) begin
        checkOutput($sformatf("rr_i_rdata_%0d", t), i_rdata[1], 32'hB000_0004);
      end else begin
        checkOutput($sformatf("rr_m_we_%0d", t), 32'(m_we[1]), 32'd1);
        checkOutput($sformatf("rr_m_addr_%0d", t), m_addr[1], 32'h8);
        checkOutput($sformatf("rr_m_wdata_%0d", t), m_wdata[1], 32'h0000_0064);
      end
      tick();
      if (t == 3) applyStimulus(1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h8, '0);
    end
    settle();
    checkOutput("rr_mem2", mem[1][2], 32'h0000_0064);
    checkOutput("rr_end_m_valid", 32'(m_valid[1]), 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
